// File: rtl/uart_rx_pkg.sv
// Shared types and defaults for the UART receive-side frame buffer.
package uart_rx_pkg;

  localparam int UART_DATA_WIDTH  = 8;
  localparam int UART_RXBUF_DEPTH = 8;

  typedef struct packed {
    logic [UART_DATA_WIDTH-1:0] data;
    logic                       par_err;
    logic                       stp_err;
  } rx_entry_t;

endpackage

// File: rtl/uart_rx_buf_mem.sv
// Frame storage: synchronous write, asynchronous read, storage not reset.
module uart_rx_buf_mem
  import uart_rx_pkg::*;
#(
  parameter int  DEPTH      = UART_RXBUF_DEPTH,
  parameter int  ADDR_WIDTH = $clog2(DEPTH),
  parameter type entry_t    = rx_entry_t
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  entry_t                wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output entry_t                rd_data
);

  entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_buffer.sv
// Receive frame buffer: edge-detected capture into a FWFT FIFO with overrun
// detection and optional discard of frames carrying parity/stop errors.
module uart_rx_buffer
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int DEPTH      = UART_RXBUF_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter bit DROP_ERR   = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  data_valid,
  input  logic                  par_err,
  input  logic                  stp_err,
  input  logic                  rd_ready,
  input  logic                  ovr_clr,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_par_err,
  output logic                  rd_stp_err,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  full,
  output logic                  empty,
  output logic                  overrun,
  output logic [7:0]            err_drop_cnt
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  par_err;
    logic                  stp_err;
  } entry_t;

  localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

  logic                dv_q;
  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic                push_req;
  logic                drop;
  logic                push;
  logic                pop;
  logic                wr_en;
  logic                ovr_set;
  entry_t              wr_entry;
  entry_t              head;

  assign push_req = data_valid & ~dv_q;
  assign drop     = DROP_ERR & push_req & (par_err | stp_err);
  assign push     = push_req & ~drop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                 (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  assign fifo_count = wr_ptr - rd_ptr;

  assign pop = ~empty & rd_ready;
  // When full, a same-cycle pop frees the slot the push is about to overwrite.
  assign wr_en   = push & (~full | pop);
  assign ovr_set = push & full & ~pop;

  assign wr_entry = '{data: P_DATA, par_err: par_err, stp_err: stp_err};

  uart_rx_buf_mem #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .entry_t    (entry_t)
  ) u_mem (
    .clk     (CLK),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
    .rd_data (head)
  );

  assign rd_valid   = ~empty;
  assign rd_data    = empty ? '0 : head.data;
  assign rd_par_err = ~empty & head.par_err;
  assign rd_stp_err = ~empty & head.stp_err;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      dv_q         <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      overrun      <= 1'b0;
      err_drop_cnt <= '0;
    end else begin
      dv_q <= data_valid;
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
      if (ovr_set)      overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
      if (drop && err_drop_cnt != 8'hFF) err_drop_cnt <= err_drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed bench for uart_rx_buffer; one instance keeps error frames, one drops them.
module tb_uart_rx_buffer;

  logic       CLK;
  logic       RST;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;
  logic       rd_ready;
  logic       ovr_clr;

  logic       rd_valid,   rd_valid_d;
  logic [7:0] rd_data,    rd_data_d;
  logic       rd_par_err, rd_par_err_d;
  logic       rd_stp_err, rd_stp_err_d;
  logic [3:0] fifo_count, fifo_count_d;
  logic       full,       full_d;
  logic       empty,      empty_d;
  logic       overrun,    overrun_d;
  logic [7:0] err_drop_cnt, err_drop_cnt_d;

  int total = 0;
  int bad   = 0;

  uart_rx_buffer #(.DROP_ERR(1'b0)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .data_valid(data_valid),
    .par_err(par_err), .stp_err(stp_err), .rd_ready(rd_ready), .ovr_clr(ovr_clr),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_par_err(rd_par_err),
    .rd_stp_err(rd_stp_err), .fifo_count(fifo_count), .full(full), .empty(empty),
    .overrun(overrun), .err_drop_cnt(err_drop_cnt)
  );

  uart_rx_buffer #(.DROP_ERR(1'b1)) dut_drop (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .data_valid(data_valid),
    .par_err(par_err), .stp_err(stp_err), .rd_ready(rd_ready), .ovr_clr(ovr_clr),
    .rd_valid(rd_valid_d), .rd_data(rd_data_d), .rd_par_err(rd_par_err_d),
    .rd_stp_err(rd_stp_err_d), .fifo_count(fifo_count_d), .full(full_d),
    .empty(empty_d), .overrun(overrun_d), .err_drop_cnt(err_drop_cnt_d)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pe, input logic se,
                            input int hold);
    P_DATA = d; par_err = pe; stp_err = se; data_valid = 1'b1;
    repeat (hold) tick();
    data_valid = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    RST = 1'b0; P_DATA = '0; data_valid = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    rd_ready = 1'b0; ovr_clr = 1'b0;
    tick(); tick();
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b want 1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", full); end
    total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
    total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    total++; if (err_drop_cnt_d !== 8'd0) begin bad++; $display("FAIL reset_drop_cnt: got %0d want 0", err_drop_cnt_d); end
    RST = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] exp [3];
    exp[0] = 8'hA5; exp[1] = 8'h3C; exp[2] = 8'hFF;
    rd_ready = 1'b0;
    P_DATA = 8'hA5; data_valid = 1'b1;
    tick();
    total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL basic_latency_valid: got %b want 1", rd_valid); end
    total++; if (rd_data !== 8'hA5) begin bad++; $display("FAIL basic_latency_data: got %h want a5", rd_data); end
    tick();
    data_valid = 1'b0;
    tick();
    send_frame(8'h3C, 1'b0, 1'b0, 2);
    send_frame(8'hFF, 1'b0, 1'b0, 2);
    total++; if (fifo_count !== 4'd3) begin bad++; $display("FAIL basic_count: got %0d want 3", fifo_count); end
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++; if (rd_data !== exp[i]) begin bad++; $display("FAIL basic_order[%0d]: got %h want %h", i, rd_data, exp[i]); end
      tick();
    end
    rd_ready = 1'b0;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL basic_drained: got empty=%b want 1", empty); end
  endtask

  task automatic test_overrun();
    logic [7:0] want;
    rd_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_frame(8'(i), 1'b0, 1'b0, 1);
    total++; if (full !== 1'b1) begin bad++; $display("FAIL ovr_full: got %b want 1", full); end
    total++; if (fifo_count !== 4'd8) begin bad++; $display("FAIL ovr_count8: got %0d want 8", fifo_count); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_not_yet: got %b want 0", overrun); end
    send_frame(8'h08, 1'b0, 1'b0, 1);
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set: got %b want 1", overrun); end
    total++; if (fifo_count !== 4'd8) begin bad++; $display("FAIL ovr_count_hold: got %0d want 8", fifo_count); end
    total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL ovr_head: got %h want 00", rd_data); end
    ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clr: got %b want 0", overrun); end
    // full with simultaneous push and pop
    P_DATA = 8'h55; data_valid = 1'b1; rd_ready = 1'b1;
    tick();
    data_valid = 1'b0; rd_ready = 1'b0;
    total++; if (fifo_count !== 4'd8) begin bad++; $display("FAIL simul_count: got %0d want 8", fifo_count); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL simul_overrun: got %b want 0", overrun); end
    total++; if (rd_data !== 8'h01) begin bad++; $display("FAIL simul_head: got %h want 01", rd_data); end
    tick();
    // new overrun in the same cycle as ovr_clr keeps the flag set
    P_DATA = 8'h66; data_valid = 1'b1; ovr_clr = 1'b1;
    tick();
    data_valid = 1'b0; ovr_clr = 1'b0;
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set_wins: got %b want 1", overrun); end
    tick();
    ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
    rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      want = (i < 7) ? 8'(i + 1) : 8'h55;
      total++; if (rd_data !== want) begin bad++; $display("FAIL ovr_contents[%0d]: got %h want %h", i, rd_data, want); end
      tick();
    end
    rd_ready = 1'b0;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL ovr_drained: got empty=%b want 1", empty); end
  endtask

  task automatic test_drop();
    RST = 1'b0; tick(); RST = 1'b1;
    rd_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0, 1);
    send_frame(8'h22, 1'b1, 1'b0, 1);
    send_frame(8'h33, 1'b0, 1'b1, 1);
    total++; if (fifo_count !== 4'd3) begin bad++; $display("FAIL keep_count: got %0d want 3", fifo_count); end
    total++; if (fifo_count_d !== 4'd1) begin bad++; $display("FAIL drop_count: got %0d want 1", fifo_count_d); end
    total++; if (err_drop_cnt_d !== 8'd2) begin bad++; $display("FAIL drop_cnt: got %0d want 2", err_drop_cnt_d); end
    total++; if (err_drop_cnt !== 8'd0) begin bad++; $display("FAIL keep_drop_cnt: got %0d want 0", err_drop_cnt); end
    total++; if (overrun_d !== 1'b0) begin bad++; $display("FAIL drop_no_overrun: got %b want 0", overrun_d); end
    total++; if (rd_data_d !== 8'h11) begin bad++; $display("FAIL drop_head: got %h want 11", rd_data_d); end
    total++; if ({rd_data, rd_par_err, rd_stp_err} !== {8'h11, 2'b00})
      begin bad++; $display("FAIL keep_e0: got %h/%b%b want 11/00", rd_data, rd_par_err, rd_stp_err); end
    rd_ready = 1'b1;
    tick();
    total++; if (empty_d !== 1'b1) begin bad++; $display("FAIL drop_empty: got %b want 1", empty_d); end
    total++; if ({rd_data, rd_par_err, rd_stp_err} !== {8'h22, 2'b10})
      begin bad++; $display("FAIL keep_e1: got %h/%b%b want 22/10", rd_data, rd_par_err, rd_stp_err); end
    tick();
    total++; if (fifo_count_d !== 4'd0) begin bad++; $display("FAIL drop_ready_empty: got %0d want 0", fifo_count_d); end
    total++; if ({rd_data, rd_par_err, rd_stp_err} !== {8'h33, 2'b01})
      begin bad++; $display("FAIL keep_e2: got %h/%b%b want 33/01", rd_data, rd_par_err, rd_stp_err); end
    tick();
    rd_ready = 1'b0;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL keep_drained: got %b want 1", empty); end
  endtask

  task automatic test_stream();
    logic [7:0] q [$];
    int  sent = 0;
    int  cyc  = 0;
    logic dv_prev = 1'b0;
    while ((sent < 20 || q.size() != 0) && cyc < 400) begin
      rd_ready = 1'($urandom_range(0, 1));
      if (data_valid) data_valid = 1'b0;
      else if (sent < 20 && q.size() < 8) begin
        P_DATA = 8'(8'h40 + sent);
        data_valid = 1'b1;
        sent++;
      end
      total++; if (rd_valid !== (q.size() != 0)) begin bad++; $display("FAIL stream_valid@%0d: got %b want %b", cyc, rd_valid, q.size() != 0); end
      total++; if (fifo_count !== 4'(q.size())) begin bad++; $display("FAIL stream_count@%0d: got %0d want %0d", cyc, fifo_count, q.size()); end
      if (q.size() != 0 && rd_ready) begin
        total++; if (rd_data !== q[0]) begin bad++; $display("FAIL stream_data@%0d: got %h want %h", cyc, rd_data, q[0]); end
        void'(q.pop_front());
      end
      if (data_valid && !dv_prev) q.push_back(P_DATA);
      dv_prev = data_valid;
      tick();
      cyc++;
    end
    data_valid = 1'b0; rd_ready = 1'b0;
    total++; if (cyc >= 400) begin bad++; $display("FAIL stream_timeout: got %0d cycles want <400", cyc); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL stream_overrun: got %b want 0", overrun); end
    tick();
  endtask

  task automatic test_saturate();
    rd_ready = 1'b0;
    for (int i = 0; i < 253; i++) send_frame(8'hE0, 1'b1, 1'b0, 1);
    total++; if (err_drop_cnt_d !== 8'd255) begin bad++; $display("FAIL sat_reach: got %0d want 255", err_drop_cnt_d); end
    send_frame(8'hE1, 1'b0, 1'b1, 1);
    send_frame(8'hE2, 1'b1, 1'b1, 1);
    total++; if (err_drop_cnt_d !== 8'd255) begin bad++; $display("FAIL sat_hold: got %0d want 255", err_drop_cnt_d); end
    total++; if (overrun_d !== 1'b0) begin bad++; $display("FAIL sat_no_overrun: got %b want 0", overrun_d); end
  endtask

  task automatic test_reset_mid();
    RST = 1'b0; tick(); RST = 1'b1;
    rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_frame(8'(8'h70 + i), 1'b0, 1'b0, 1);
    total++; if (fifo_count !== 4'd5) begin bad++; $display("FAIL mid_count5: got %0d want 5", fifo_count); end
    rd_ready = 1'b1;
    tick();
    RST = 1'b0;
    tick();
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL mid_empty: got %b want 1", empty); end
    total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL mid_count0: got %0d want 0", fifo_count); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL mid_rd_valid: got %b want 0", rd_valid); end
    RST = 1'b1; rd_ready = 1'b0;
    send_frame(8'h9C, 1'b0, 1'b0, 1);
    total++; if (rd_data !== 8'h9C) begin bad++; $display("FAIL mid_head: got %h want 9c", rd_data); end
    total++; if (fifo_count !== 4'd1) begin bad++; $display("FAIL mid_count1: got %0d want 1", fifo_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_drop();
    test_stream();
    test_saturate();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
